// File: rtl/multi_shot_controller_pkg.sv
// Shared constants, slot state type and index-width helper for the multi-shot projectile pool.
package shot_pkg;

   localparam int X_MAX           = 639;
   localparam int Y_MAX           = 479;
   localparam int Y_TOP_LIMIT_DEF = 36;
   localparam int COORD_W_DEF     = 10;

   typedef struct packed {
      logic                   active;
      logic [COORD_W_DEF-1:0] x;
      logic [COORD_W_DEF-1:0] y;
   } shot_state_t;

   // Slot index width; a single-slot pool still gets a 1-bit index.
   function automatic int slot_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_shot_controller_shot_slot.sv
// One projectile slot: holds active/x/y, handles load, hit, per-frame move and top retirement,
// and flags whether it covers the current scan pixel.
module shot_slot
   import shot_pkg::*;
#(
   parameter int COORD_W     = COORD_W_DEF,
   parameter int SHOT_W      = 2,
   parameter int SHOT_H      = 8,
   parameter int SHOT_VEL    = 4,
   parameter int Y_TOP_LIMIT = Y_TOP_LIMIT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               refresh_tick,
   input  logic               hit,
   input  logic               load,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   output logic               active,
   output logic               covers
);

   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [COORD_W:0]   x_end;
   logic [COORD_W:0]   y_end;

   // Load only ever targets a slot that was free, so it cannot collide with a real hit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         active <= 1'b0;
         x      <= '0;
         y      <= '0;
      end else if (load) begin
         active <= 1'b1;
         x      <= load_x;
         y      <= load_y;
      end else if (hit) begin
         active <= 1'b0;
      end else if (refresh_tick && active) begin
         if (int'(y) < Y_TOP_LIMIT + SHOT_VEL)
            active <= 1'b0;
         else
            y <= y - COORD_W'(SHOT_VEL);
      end
   end

   // One extra bit keeps the right/bottom edge from wrapping near the coordinate limit.
   always_comb begin
      x_end  = {1'b0, x} + (COORD_W+1)'(SHOT_W - 1);
      y_end  = {1'b0, y} + (COORD_W+1)'(SHOT_H - 1);
      covers = active &&
               (pixel_x >= x) && ({1'b0, pixel_x} <= x_end) &&
               (pixel_y >= y) && ({1'b0, pixel_y} <= y_end);
   end

endmodule

// File: rtl/multi_shot_controller.sv
// Pool of N_SHOTS player projectiles: fire capture, cooldown, lowest-free allocation, hit clearing
// and per-pixel rendering. Define SHOT_AUTOFIRE_EN for level-sensitive (held-button) fire.
module multi_shot_controller
   import shot_pkg::*;
#(
   parameter int N_SHOTS         = 4,
   parameter int COORD_W         = COORD_W_DEF,
   parameter int SHOT_W          = 2,
   parameter int SHOT_H          = 8,
   parameter int SHOT_VEL        = 4,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int Y_TOP_LIMIT     = Y_TOP_LIMIT_DEF,
   parameter int IDX_W           = slot_idx_w(N_SHOTS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               refresh_tick,
   input  logic               fire,
   input  logic [COORD_W-1:0] orig_x,
   input  logic [COORD_W-1:0] orig_y,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic               hit_valid,
   input  logic [IDX_W-1:0]   hit_slot,
   output logic               shot_pixel,
   output logic [IDX_W-1:0]   shot_slot,
   output logic [N_SHOTS-1:0] active_mask,
   output logic               fire_accepted,
   output logic [15:0]        shots_fired
);

   localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   logic               fire_q;
   logic               pending;
   logic [CD_W-1:0]    cooldown;
   logic               any_free;
   logic [IDX_W-1:0]   alloc_idx;
   logic               try_alloc;
   logic               spawn_ok;
   logic               do_alloc;
   logic               drop;
   logic               hit_ok;
   logic [COORD_W-1:0] spawn_x;
   logic [COORD_W-1:0] spawn_y;
   logic [N_SHOTS-1:0] load_vec;
   logic [N_SHOTS-1:0] hit_vec;
   logic [N_SHOTS-1:0] covers;

   // Allocation looks at start-of-cycle occupancy, so slots freed this cycle wait a tick.
   always_comb begin
      any_free  = 1'b0;
      alloc_idx = '0;
      for (int i = N_SHOTS - 1; i >= 0; i--) begin
         if (!active_mask[i]) begin
            any_free  = 1'b1;
            alloc_idx = IDX_W'(i);
         end
      end
      try_alloc = refresh_tick && pending && (cooldown == '0);
      spawn_ok  = (orig_y >= COORD_W'(SHOT_H));
      do_alloc  = try_alloc && spawn_ok && any_free;
      drop      = try_alloc && !spawn_ok;
      spawn_x   = orig_x - COORD_W'(SHOT_W / 2);
      spawn_y   = orig_y - COORD_W'(SHOT_H);
      hit_ok    = hit_valid && (int'(hit_slot) < N_SHOTS);
      for (int i = 0; i < N_SHOTS; i++) begin
         load_vec[i] = do_alloc && (alloc_idx == IDX_W'(i));
         hit_vec[i]  = hit_ok && (hit_slot == IDX_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fire_q        <= 1'b0;
         pending       <= 1'b0;
         cooldown      <= '0;
         fire_accepted <= 1'b0;
         shots_fired   <= '0;
      end else begin
         fire_q        <= fire;
         fire_accepted <= do_alloc;
`ifdef SHOT_AUTOFIRE_EN
         if (fire)
            pending <= 1'b1;
         else if (do_alloc || drop)
            pending <= 1'b0;
`else
         if (do_alloc || drop)
            pending <= 1'b0;
         else if (fire && !fire_q)
            pending <= 1'b1;
`endif
         if (do_alloc)
            cooldown <= CD_W'(COOLDOWN_FRAMES);
         else if (refresh_tick && (cooldown != '0))
            cooldown <= cooldown - CD_W'(1);
         if (do_alloc && (shots_fired != 16'hFFFF))
            shots_fired <= shots_fired + 16'd1;
      end
   end

   for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
      shot_slot #(
         .COORD_W    (COORD_W),
         .SHOT_W     (SHOT_W),
         .SHOT_H     (SHOT_H),
         .SHOT_VEL   (SHOT_VEL),
         .Y_TOP_LIMIT(Y_TOP_LIMIT)
      ) u_slot (
         .clk         (clk),
         .reset       (reset),
         .refresh_tick(refresh_tick),
         .hit         (hit_vec[g]),
         .load        (load_vec[g]),
         .load_x      (spawn_x),
         .load_y      (spawn_y),
         .pixel_x     (pixel_x),
         .pixel_y     (pixel_y),
         .active      (active_mask[g]),
         .covers      (covers[g])
      );
   end

   // Render path is purely combinational; lowest covering slot wins.
   always_comb begin
      shot_pixel = reset && (|covers);
      shot_slot  = '0;
      for (int i = N_SHOTS - 1; i >= 0; i--) begin
         if (reset && covers[i])
            shot_slot = IDX_W'(i);
      end
   end

endmodule

// File: tb/tb_multi_shot_controller.sv
// Directed self-checking bench for multi_shot_controller (default build, edge-triggered fire).
module tb_multi_shot_controller;

   localparam int CW = 10;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          refresh_tick = 1'b0;
   logic          fire = 1'b0;
   logic [CW-1:0] orig_x = 10'd320;
   logic [CW-1:0] orig_y = 10'd420;
   logic [CW-1:0] pixel_x = '0;
   logic [CW-1:0] pixel_y = '0;
   logic          hit_valid = 1'b0;
   logic [IW-1:0] hit_slot = '0;
   logic          shot_pixel;
   logic [IW-1:0] shot_slot;
   logic [3:0]    active_mask;
   logic          fire_accepted;
   logic [15:0]   shots_fired;

   int n_checks = 0;
   int n_fail   = 0;

   multi_shot_controller dut (
      .clk          (clk),
      .reset        (reset),
      .refresh_tick (refresh_tick),
      .fire         (fire),
      .orig_x       (orig_x),
      .orig_y       (orig_y),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .hit_valid    (hit_valid),
      .hit_slot     (hit_slot),
      .shot_pixel   (shot_pixel),
      .shot_slot    (shot_slot),
      .active_mask  (active_mask),
      .fire_accepted(fire_accepted),
      .shots_fired  (shots_fired)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fire_edge();
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      cyc(1);
   endtask

   task automatic tick();
      refresh_tick = 1'b1;
      cyc(1);
      refresh_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      refresh_tick = 1'b1;
      cyc(1);
      refresh_tick = 1'b0;
      cyc(1);
      pixel_x = 10'd0;
      pixel_y = 10'd0;
      #1;
      n_checks++;
      if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", active_mask); end
      n_checks++;
      if (fire_accepted !== 1'b0) begin n_fail++; $display("FAIL reset_accept: got %b want 0", fire_accepted); end
      n_checks++;
      if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", shots_fired); end
      n_checks++;
      if (shot_pixel !== 1'b0 || shot_slot !== 2'd0) begin
         n_fail++; $display("FAIL reset_render: got pix=%b slot=%0d want 0/0", shot_pixel, shot_slot);
      end
      reset = 1'b1;
      cyc(1);
      tick();
      n_checks++;
      if (fire_accepted !== 1'b0) begin n_fail++; $display("FAIL reset_no_pending: got %b want 0", fire_accepted); end
   endtask

   task automatic test_single_shot();
      orig_x = 10'd320;
      orig_y = 10'd420;
      fire_edge();
      tick();
      n_checks++;
      if (active_mask !== 4'b0001) begin n_fail++; $display("FAIL single_mask: got %b want 0001", active_mask); end
      n_checks++;
      if (fire_accepted !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", fire_accepted); end
      n_checks++;
      if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", shots_fired); end
      cyc(1);
      n_checks++;
      if (fire_accepted !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", fire_accepted); end
   endtask

   task automatic test_render();
      logic [CW-1:0] px [6] = '{10'd319, 10'd320, 10'd321, 10'd319, 10'd318, 10'd319};
      logic [CW-1:0] py [6] = '{10'd412, 10'd419, 10'd412, 10'd420, 10'd412, 10'd411};
      logic          ep [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         pixel_x = px[i];
         pixel_y = py[i];
         #1;
         n_checks++;
         if (shot_pixel !== ep[i] || shot_slot !== 2'd0) begin
            n_fail++;
            $display("FAIL render_%0d (%0d,%0d): got pix=%b slot=%0d want pix=%b slot=0",
                     i, px[i], py[i], shot_pixel, shot_slot, ep[i]);
         end
      end
   endtask

   task automatic test_cooldown_fill();
      logic [3:0] exp_mask [3] = '{4'b0011, 4'b0111, 4'b1111};
      for (int r = 1; r <= 3; r++) begin
         orig_y = (r == 2) ? 10'd348 : 10'd420;
         for (int k = 1; k <= 9; k++) begin
            fire_edge();
            tick();
            n_checks++;
            if (fire_accepted !== (k == 9)) begin
               n_fail++;
               $display("FAIL cooldown_r%0d_t%0d: got accept=%b want %b", r, k, fire_accepted, (k == 9));
            end
         end
         n_checks++;
         if (active_mask !== exp_mask[r-1]) begin
            n_fail++; $display("FAIL fill_mask_r%0d: got %b want %b", r, active_mask, exp_mask[r-1]);
         end
         n_checks++;
         if (shots_fired !== 16'(r + 1)) begin
            n_fail++; $display("FAIL fill_count_r%0d: got %0d want %0d", r, shots_fired, r + 1);
         end
         if (r == 2) begin
            pixel_x = 10'd319;
            pixel_y = 10'd340;
            #1;
            n_checks++;
            if (shot_pixel !== 1'b1 || shot_slot !== 2'd0) begin
               n_fail++; $display("FAIL overlap_a: got pix=%b slot=%0d want 1/0", shot_pixel, shot_slot);
            end
            pixel_x = 10'd320;
            pixel_y = 10'd347;
            #1;
            n_checks++;
            if (shot_pixel !== 1'b1 || shot_slot !== 2'd0) begin
               n_fail++; $display("FAIL overlap_b: got pix=%b slot=%0d want 1/0", shot_pixel, shot_slot);
            end
         end
      end
      orig_y = 10'd420;
   endtask

   task automatic test_full_pending();
      fire_edge();
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if (fire_accepted !== 1'b0) begin
            n_fail++; $display("FAIL full_t%0d: got accept=%b want 0", k, fire_accepted);
         end
      end
      n_checks++;
      if (active_mask !== 4'b1111) begin n_fail++; $display("FAIL full_mask: got %b want 1111", active_mask); end
   endtask

   task automatic test_hit_vs_tick();
      hit_valid = 1'b1;
      hit_slot = 2'd1;
      refresh_tick = 1'b1;
      cyc(1);
      hit_valid = 1'b0;
      refresh_tick = 1'b0;
      n_checks++;
      if (active_mask !== 4'b1101) begin n_fail++; $display("FAIL hit_mask: got %b want 1101", active_mask); end
      n_checks++;
      if (fire_accepted !== 1'b0) begin n_fail++; $display("FAIL hit_no_realloc: got %b want 0", fire_accepted); end
      tick();
      n_checks++;
      if (fire_accepted !== 1'b1) begin n_fail++; $display("FAIL hit_next_accept: got %b want 1", fire_accepted); end
      n_checks++;
      if (active_mask !== 4'b1111) begin n_fail++; $display("FAIL hit_refill_mask: got %b want 1111", active_mask); end
      n_checks++;
      if (shots_fired !== 16'd5) begin n_fail++; $display("FAIL hit_count: got %0d want 5", shots_fired); end
      pixel_x = 10'd319;
      pixel_y = 10'd412;
      #1;
      n_checks++;
      if (shot_pixel !== 1'b1 || shot_slot !== 2'd1) begin
         n_fail++; $display("FAIL hit_refill_render: got pix=%b slot=%0d want 1/1", shot_pixel, shot_slot);
      end
   endtask

   task automatic test_reset_midflight();
      fire_edge();
      reset = 1'b0;
      cyc(1);
      n_checks++;
      if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_mask: got %b want 0000", active_mask); end
      n_checks++;
      if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", shots_fired); end
      reset = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if (fire_accepted !== 1'b0 || active_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_t%0d: got accept=%b mask=%b want 0/0000", k, fire_accepted, active_mask);
         end
      end
   endtask

   task automatic test_spawn_guard();
      orig_y = 10'd5;
      fire_edge();
      tick();
      n_checks++;
      if (fire_accepted !== 1'b0 || active_mask !== 4'b0000) begin
         n_fail++; $display("FAIL guard_drop: got accept=%b mask=%b want 0/0000", fire_accepted, active_mask);
      end
      orig_y = 10'd48;
      tick();
      n_checks++;
      if (fire_accepted !== 1'b0) begin n_fail++; $display("FAIL guard_cleared: got %b want 0", fire_accepted); end
   endtask

   task automatic test_retire();
      orig_y = 10'd48;
      fire_edge();
      tick();
      n_checks++;
      if (fire_accepted !== 1'b1 || active_mask !== 4'b0001) begin
         n_fail++; $display("FAIL retire_spawn: got accept=%b mask=%b want 1/0001", fire_accepted, active_mask);
      end
      pixel_x = 10'd319;
      pixel_y = 10'd40;
      #1;
      n_checks++;
      if (shot_pixel !== 1'b1) begin n_fail++; $display("FAIL retire_y40: got %b want 1", shot_pixel); end
      tick();
      pixel_y = 10'd36;
      #1;
      n_checks++;
      if (shot_pixel !== 1'b1 || active_mask !== 4'b0001) begin
         n_fail++; $display("FAIL retire_y36: got pix=%b mask=%b want 1/0001", shot_pixel, active_mask);
      end
      pixel_y = 10'd35;
      #1;
      n_checks++;
      if (shot_pixel !== 1'b0) begin n_fail++; $display("FAIL retire_y35: got %b want 0", shot_pixel); end
      tick();
      n_checks++;
      if (active_mask !== 4'b0000) begin n_fail++; $display("FAIL retire_gone: got %b want 0000", active_mask); end
      n_checks++;
      if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL retire_count: got %0d want 1", shots_fired); end
   endtask

   initial begin
      cyc(1);
      test_reset();
      test_single_shot();
      test_render();
      test_cooldown_fill();
      test_full_pending();
      test_hit_vs_tick();
      test_reset_midflight();
      test_spawn_guard();
      test_retire();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
